amx_seq_ctrl: RTL and testbench



---
 rtl/amx_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_amx_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amx_seq_ctrl.sv
// amx_seq_ctrl: command sequencer for the AMX core datapath.
// Parses a host byte stream (header + payload), streams operands to the core,
// issues the start strobe, buffers core results in a small FIFO and returns
// them to the host over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_byte/in_valid/in_ready      host command/payload input (handshake)
//   core_data/core_load            operand byte strobe to the core
//   core_op                        opcode, held from START until next header
//   core_start                     one-cycle start strobe
//   core_done                      core completion (pulse or level)
//   core_result/core_res_valid     result bytes from the core (no backpressure)
//   out_byte/out_valid/out_ready   result stream to the host (handshake)
//   busy                           controller not in IDLE
//   err                            sticky error (bad len, overflow, timeout)
module amx_seq_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] core_data,
    output logic       core_load,
    output logic [2:0] core_op,
    output logic       core_start,
    input  logic       core_done,
    input  logic [7:0] core_result,
    input  logic       core_res_valid,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    logic [3:0]         r_len;
    logic [3:0]         r_pcnt;
    logic [7:0]         r_tcnt;
    logic [7:0]         r_mem [MAX_LEN];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               r_in_ready;
    logic [7:0]         r_core_data;
    logic               r_core_load;
    logic [2:0]         r_core_op;
    logic               r_core_start;
    logic [7:0]         r_out_byte;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_err;

    state_t             w_state_n;
    logic               w_err_n;
    logic               w_in_hs;
    logic               w_hdr_ok;
    logic               w_len_bad;
    logic               w_push;
    logic               w_full;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_n;
    logic [PTR_W-1:0]   w_rd_ptr_n;
    logic [7:0]         w_head_n;
    logic               w_out_valid_n;

    // Next-state, FIFO bookkeeping and error logic.
    always_comb begin
        w_state_n  = r_state;
        w_err_n    = r_err;
        w_hdr_ok   = 1'b0;
        w_in_hs    = in_valid && r_in_ready;
        w_len_bad  = (in_byte[3:0] == 4'd0) || (5'({1'b0, in_byte[3:0]}) > 5'(MAX_LEN));
        w_push     = (r_state == S_WAIT) && core_res_valid;
        w_full     = (r_count == CNT_W'(MAX_LEN));
        w_pop      = (r_state == S_DRAIN) && r_out_valid && out_ready;

        if (w_push && !w_full) begin
            w_count_n = r_count + 1'b1;
        end else if (w_pop) begin
            w_count_n = r_count - 1'b1;
        end else begin
            w_count_n = r_count;
        end
        w_rd_ptr_n = w_pop ? PTR_W'(r_rd_ptr + 1'b1) : r_rd_ptr;
        // Show-ahead head: an empty FIFO being written presents the new byte directly.
        w_head_n   = (r_count == '0) ? core_result : r_mem[w_rd_ptr_n];

        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    if (in_byte[7:5] == 3'b111) begin
                        w_err_n = 1'b0;
                    end else if (w_len_bad) begin
                        w_err_n = 1'b1;
                    end else begin
                        w_hdr_ok  = 1'b1;
                        w_state_n = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_in_hs && (4'(r_pcnt + 4'd1) == r_len)) begin
                    w_state_n = S_START;
                end
            end
            S_START: begin
                w_state_n = S_WAIT;
            end
            S_WAIT: begin
                if (w_push && w_full) begin
                    w_err_n = 1'b1;
                end
                if (core_done) begin
                    w_state_n = S_DRAIN;
                end else if (r_tcnt == 8'(TIMEOUT - 1)) begin
                    w_err_n   = 1'b1;
                    w_state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_count_n == '0) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_out_valid_n = (w_state_n == S_DRAIN) && (w_count_n != '0);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_len        <= 4'd0;
            r_pcnt       <= 4'd0;
            r_tcnt       <= 8'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_in_ready   <= 1'b1;
            r_core_data  <= 8'd0;
            r_core_load  <= 1'b0;
            r_core_op    <= 3'd0;
            r_core_start <= 1'b0;
            r_out_byte   <= 8'd0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_err        <= w_err_n;
            r_in_ready   <= (w_state_n == S_IDLE) || (w_state_n == S_LOAD);
            r_busy       <= (w_state_n != S_IDLE);
            r_core_start <= (w_state_n == S_START);
            r_core_load  <= (r_state == S_LOAD) && w_in_hs;

            if ((r_state == S_LOAD) && w_in_hs) begin
                r_core_data <= in_byte;
                r_pcnt      <= r_pcnt + 4'd1;
            end
            if (w_hdr_ok) begin
                r_core_op <= in_byte[7:5];
                r_len     <= in_byte[3:0];
                r_pcnt    <= 4'd0;
            end

            if (r_state == S_START) begin
                r_tcnt <= 8'd0;
            end else if (r_state == S_WAIT) begin
                r_tcnt <= r_tcnt + 8'd1;
            end

            if (w_push && !w_full) begin
                r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
            end
            r_rd_ptr    <= w_rd_ptr_n;
            r_count     <= w_count_n;
            r_out_valid <= w_out_valid_n;
            // Only refresh the output byte while it is presented, so it holds under backpressure.
            if (w_out_valid_n) begin
                r_out_byte <= w_head_n;
            end
        end
    end

    // FIFO storage; contents need no reset since count governs validity.
    always_ff @(posedge clk) begin
        if (w_push && !w_full) begin
            r_mem[r_wr_ptr] <= core_result;
        end
    end

    assign in_ready   = r_in_ready;
    assign core_data  = r_core_data;
    assign core_load  = r_core_load;
    assign core_op    = r_core_op;
    assign core_start = r_core_start;
    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_amx_seq_ctrl.sv
// Bench for amx_seq_ctrl: directed commands with a queue-based scoreboard.
module tb_amx_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_byte = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] core_data;
    logic       core_load;
    logic [2:0] core_op;
    logic       core_start;
    logic       core_done = 1'b0;
    logic [7:0] core_result = 8'd0;
    logic       core_res_valid = 1'b0;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       err;

    amx_seq_ctrl #(.MAX_LEN(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .core_data(core_data), .core_load(core_load), .core_op(core_op),
        .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .core_res_valid(core_res_valid),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_starts = 0;
    int start_cyc = 0;
    int last_pop_cyc = 0;
    int idle_cyc = 0;
    logic [7:0] exp_load[$];
    logic [7:0] exp_out[$];
    int load_cyc[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operand monitor: every core_load must match the next expected payload byte.
    always @(negedge clk) begin
        if (rst_n && core_load) begin
            if (exp_load.size() == 0) begin
                chk("core_load unexpected", core_load, 0);
            end else begin
                chk("core_data", core_data, exp_load.pop_front());
                load_cyc.push_back(cyc);
            end
        end
        if (rst_n && core_start) begin
            n_starts++;
            start_cyc = cyc;
        end
    end

    // Result monitor: ordered delivery plus hold-under-backpressure.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("out_valid hold", out_valid, 1);
                chk("out_byte hold", out_byte, prev_byte);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    chk("out_valid unexpected", out_valid, 0);
                end else begin
                    chk("out_byte", out_byte, exp_out.pop_front());
                end
                last_pop_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        in_byte  = b;
        in_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) chk("in_ready wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'd0;
    endtask

    task automatic wait_start();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_start) break;
        end
        if (k == 50) chk("core_start wait", core_start, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic core_emit(input logic [7:0] b);
        core_result    = b;
        core_res_valid = 1'b1;
        tick();
        core_res_valid = 1'b0;
        core_result    = 8'd0;
    endtask

    task automatic core_finish();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        idle_cyc = cyc;
        chk(name, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("reset in_ready", in_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset core_op", core_op, 0);

        // Reset asserted mid-LOAD aborts and clears err
        send(8'h20);
        chk("pre-reset err", err, 1);
        send(8'h43);
        send(8'h11);
        #2 rst_n = 1'b0;
        #1;
        chk("async core_load", core_load, 0);
        chk("async core_start", core_start, 0);
        chk("async out_valid", out_valid, 0);
        chk("async busy", busy, 0);
        chk("async err", err, 0);
        chk("async in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_starts = 0;
        send(8'h23);
        chk("post-reset busy", busy, 1);
        chk("post-reset core_op", core_op, 1);
        exp_load.push_back(8'hAB);
        exp_load.push_back(8'hCD);
        exp_load.push_back(8'hEF);
        send(8'hAB);
        send(8'hCD);
        send(8'hEF);
        wait_start();
        core_finish();
        wait_idle("post-reset idle");
        chk("post-reset starts", n_starts, 1);

        // Normal command: op 2, len 3
        n_starts = 0;
        load_cyc.delete();
        exp_load.push_back(8'h11);
        exp_load.push_back(8'h22);
        exp_load.push_back(8'h33);
        send(8'h43);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        wait_start();
        chk("normal core_op", core_op, 2);
        chk("normal loads", load_cyc.size(), 3);
        if (load_cyc.size() == 3) begin
            chk("loads back-to-back", load_cyc[2] - load_cyc[0], 2);
            chk("start with last load", start_cyc, load_cyc[2]);
        end
        exp_out.push_back(8'hA0);
        exp_out.push_back(8'hA1);
        core_emit(8'hA0);
        core_emit(8'hA1);
        core_finish();
        wait_idle("normal idle");
        chk("idle after last pop", idle_cyc, last_pop_cyc + 1);
        chk("normal starts", n_starts, 1);
        chk("normal err", err, 0);

        // Backpressure: out_ready low for 5 cycles
        exp_load.push_back(8'h11);
        exp_load.push_back(8'h22);
        exp_load.push_back(8'h33);
        out_ready = 1'b0;
        send(8'h43);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        wait_start();
        exp_out.push_back(8'hA0);
        exp_out.push_back(8'hA1);
        core_emit(8'hA0);
        core_emit(8'hA1);
        core_finish();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid", out_valid, 1);
            chk("bp out_byte", out_byte, 8'hA0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("bp idle");

        // Bad lengths, boundary len=9, clear via op 7
        send(8'h20);
        chk("len0 err", err, 1);
        chk("len0 busy", busy, 0);
        chk("len0 in_ready", in_ready, 1);
        send(8'hE0);
        chk("clear err", err, 0);
        send(8'h2F);
        chk("len15 err", err, 1);
        chk("len15 busy", busy, 0);
        send(8'hE0);
        chk("clear err 2", err, 0);
        send(8'h29);
        chk("len9 err", err, 1);
        send(8'hEF);
        chk("clear err len ignored", err, 0);

        // Overflow: 9 results into an 8-deep buffer
        exp_load.push_back(8'h01);
        exp_load.push_back(8'h02);
        send(8'h42);
        send(8'h01);
        send(8'h02);
        wait_start();
        for (int i = 0; i < 8; i++) begin
            exp_out.push_back(8'(8'hB0 + i));
            core_emit(8'(8'hB0 + i));
        end
        chk("no early overflow", err, 0);
        core_emit(8'hB8);
        chk("overflow err", err, 1);
        core_finish();
        wait_idle("overflow idle");
        chk("overflow err sticky", err, 1);
        send(8'hE0);
        chk("overflow clear", err, 0);

        // Timeout: core_done never arrives
        exp_load.push_back(8'h55);
        send(8'h61);
        send(8'h55);
        wait_start();
        exp_out.push_back(8'hC0);
        exp_out.push_back(8'hC1);
        core_emit(8'hC0);
        core_emit(8'hC1);
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (err) break;
        end
        chk("timeout cycles", cyc - start_cyc, 256);
        chk("timeout busy", busy, 1);
        chk("timeout out_valid", out_valid, 1);
        chk("timeout core_op", core_op, 3);
        @(posedge clk);
        #1;
        wait_idle("timeout idle");
        chk("timeout err sticky", err, 1);

        chk("load queue drained", exp_load.size(), 0);
        chk("out queue drained", exp_out.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
